// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-update-policy definitions for the ALU writeback stage.
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdcs = 4'd0,
        OpAdd  = 4'd1,
        OpSbcs = 4'd2,
        OpSubs = 4'd3,
        OpRsbs = 4'd4,
        OpMuls = 4'd5,
        OpAnds = 4'd6,
        OpOrrs = 4'd7,
        OpCmp  = 4'd8
    } opcode_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic upd_n;
        logic upd_z;
        logic upd_c;
        logic upd_v;
        logic push;
        logic illegal;
    } upd_mask_t;

    function automatic upd_mask_t upd_mask(input logic [3:0] op);
        upd_mask_t m;
        m = '0;
        case (opcode_e'(op))
            OpAdcs, OpSbcs: begin
                m.upd_n = 1'b1;
                m.upd_z = 1'b1;
                m.upd_c = 1'b1;
                m.upd_v = 1'b1;
                m.push  = 1'b1;
            end
            OpAdd, OpSubs, OpRsbs, OpMuls, OpAnds, OpOrrs: begin
                m.upd_n = 1'b1;
                m.upd_z = 1'b1;
                m.push  = 1'b1;
            end
            OpCmp: begin
                m.upd_n = 1'b1;
                m.upd_z = 1'b1;
            end
            default: m.illegal = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order valid/ready FIFO; ready depends only on the registered occupancy.
module wb_fifo2 #(
    parameter int unsigned Width = 35
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [Width-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [Width-1:0] pop_data_o
);

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             push_en, pop_en;

    // A full FIFO refuses pushes even when it is popped in the same cycle.
    assign push_ready_o = (count_q != 2'd2);
    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign push_en      = push_valid_i && push_ready_o;
    assign pop_en       = pop_valid_o && pop_ready_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: NZCV flag register with per-opcode update policy plus 2-entry result FIFO.
// Define ALU_WB_OVF_EN to compute V for ADCS/SBCS; otherwise V is tied to 0.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_negative,
    input  logic              in_zero,
    input  logic [TAG_W-1:0]  in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_dest,
    output logic [3:0]        flags,
    output logic              err_illegal
);

    localparam int unsigned EntryW = DATA_W + TAG_W;

    upd_mask_t         upd;
    logic              accept;
    logic              is_cmp;
    logic              n_new, z_new;
    logic [3:0]        flags_q, flags_d;
    logic              err_illegal_q, err_illegal_d;
    logic [EntryW-1:0] head_data;

    assign upd    = upd_mask(in_opcode);
    assign accept = in_valid && in_ready;
    assign is_cmp = (in_opcode == OpCmp);
    // CMP carries its own N/Z from the ALU; everything else is derived from the result.
    assign n_new  = is_cmp ? in_negative : in_result[DATA_W-1];
    assign z_new  = is_cmp ? in_zero : (in_result == '0);

`ifdef ALU_WB_OVF_EN
    logic v_new;
    logic a_msb, b_msb, r_msb;

    assign a_msb = in_a[DATA_W-1];
    assign b_msb = in_b[DATA_W-1];
    assign r_msb = in_result[DATA_W-1];
    assign v_new = (in_opcode == OpSbcs) ? ((a_msb != b_msb) && (r_msb != a_msb))
                                         : ((a_msb == b_msb) && (r_msb != a_msb));
`else
    logic unused_ovf;
    assign unused_ovf = ^{in_a, in_b, upd.upd_v};
`endif

    always_comb begin
        flags_d       = flags_q;
        err_illegal_d = accept && upd.illegal;
        if (accept) begin
            if (upd.upd_n) flags_d[FLAG_N] = n_new;
            if (upd.upd_z) flags_d[FLAG_Z] = z_new;
            if (upd.upd_c) flags_d[FLAG_C] = in_carry;
`ifdef ALU_WB_OVF_EN
            if (upd.upd_v) flags_d[FLAG_V] = v_new;
`endif
        end
`ifndef ALU_WB_OVF_EN
        flags_d[FLAG_V] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q       <= 4'b0000;
            err_illegal_q <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign flags       = flags_q;
    assign err_illegal = err_illegal_q;

    wb_fifo2 #(
        .Width (EntryW)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_valid_i (in_valid && upd.push),
        .push_ready_o (in_ready),
        .push_data_i  ({in_result, in_dest}),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (head_data)
    );

    assign out_result = head_data[TAG_W +: DATA_W];
    assign out_dest   = head_data[TAG_W-1:0];

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback; expectations are hand-computed per vector.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [31:0] in_a, in_b, in_result;
    logic        in_carry, in_negative, in_zero;
    logic [2:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_dest;
    logic [3:0]  flags;
    logic        err_illegal;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    alu_writeback #(
        .DATA_W (32),
        .TAG_W  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_negative (in_negative),
        .in_zero     (in_zero),
        .in_dest     (in_dest),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_dest    (out_dest),
        .flags       (flags),
        .err_illegal (err_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic c, input logic n, input logic z,
                         input logic [2:0] dest);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_a        = a;
        in_b        = b;
        in_result   = res;
        in_carry    = c;
        in_negative = n;
        in_zero     = z;
        in_dest     = dest;
    endtask

    logic [3:0] exp_adcs;

    initial begin
`ifdef ALU_WB_OVF_EN
        exp_adcs = 4'b1001;
`else
        exp_adcs = 4'b1000;
`endif
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        in_valid  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_err", 32'(err_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_dest", 32'(out_dest), 32'd0);

        // ADD result 0 -> Z only
        drive(4'd1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 3'd3);
        tick();
        in_valid = 1'b0;
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_result", out_result, 32'd0);
        check("add_out_dest", 32'(out_dest), 32'd3);
        check("add_flags", 32'(flags), 32'b0100);
        tick();
        check("add_drained", 32'(out_valid), 32'd0);

        // ADCS signed overflow
        drive(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        check("adcs_flags", 32'(flags), 32'(exp_adcs));
        check("adcs_out_result", out_result, 32'h8000_0000);

        // SBCS carry=1 (pushed while ADCS pops), then ANDS holds C
        drive(4'd2, 32'd10, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        check("sbcs_flags", 32'(flags), 32'b0010);
        check("sbcs_head", out_result, 32'd5);
        drive(4'd6, 32'd0, 32'd0, 32'h10, 1'b0, 1'b0, 1'b0, 3'd4);
        tick();
        in_valid = 1'b0;
        check("ands_flags", 32'(flags), 32'b0010);
        check("ands_head", out_result, 32'h10);
        check("ands_valid", 32'(out_valid), 32'd1);
        tick();
        check("ands_drained", 32'(out_valid), 32'd0);

        // Fill with out_ready low; third stalls, then drain in order
        out_ready = 1'b0;
        drive(4'd1, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        drive(4'd1, 32'd0, 32'd0, 32'd2, 1'b0, 1'b0, 1'b0, 3'd2);
        tick();
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(4'd1, 32'd0, 32'd0, 32'd3, 1'b0, 1'b0, 1'b0, 3'd3);
        tick();
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_head", out_result, 32'd1);
        check("stall_dest", 32'(out_dest), 32'd1);
        out_ready = 1'b1;
        tick();
        check("drain_2", out_result, 32'd2);
        check("drain_2_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("drain_3", out_result, 32'd3);
        check("drain_3_dest", 32'(out_dest), 32'd3);
        check("drain_3_valid", 32'(out_valid), 32'd1);
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);
        check("drain_flags", 32'(flags), 32'b0010);

        // CMP stalls while full, then accepted without push
        out_ready = 1'b0;
        drive(4'd1, 32'd0, 32'd0, 32'd4, 1'b0, 1'b0, 1'b0, 3'd4);
        tick();
        drive(4'd1, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0, 1'b0, 3'd5);
        tick();
        drive(4'd8, 32'd0, 32'd0, 32'h1234, 1'b0, 1'b0, 1'b1, 3'd6);
        tick();
        check("cmp_stall_flags", 32'(flags), 32'b0010);
        check("cmp_stall_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("cmp_pop_flags", 32'(flags), 32'b0010);
        check("cmp_pop_head", out_result, 32'd5);
        tick();
        in_valid = 1'b0;
        check("cmp_flags", 32'(flags), 32'b0110);
        check("cmp_count_valid", 32'(out_valid), 32'd1);
        check("cmp_count_ready", 32'(in_ready), 32'd1);
        check("cmp_head", out_result, 32'd5);

        // Illegal opcode: pulse only
        drive(4'd12, 32'd0, 32'd0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 3'd7);
        tick();
        in_valid = 1'b0;
        check("ill_err", 32'(err_illegal), 32'd1);
        check("ill_flags", 32'(flags), 32'b0110);
        check("ill_no_push", 32'(in_ready), 32'd1);
        check("ill_head", out_result, 32'd5);
        tick();
        check("ill_pulse_end", 32'(err_illegal), 32'd0);

        // Reset with two entries queued
        drive(4'd1, 32'd0, 32'd0, 32'd7, 1'b0, 1'b0, 1'b0, 3'd7);
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_flags", 32'(flags), 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the ALU. It accepts one ALU result per handshake and maintains the architectural NZCV status register, applying a per-opcode flag-update policy. It computes Z and, optionally, V itself, and buffers results in a 2-entry FIFO toward the register-file write port.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- TAG_W, 3, destination register tag width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept
- in_opcode  in  4  ALU opcode (0 ADCS, 1 ADD, 2 SBCS, 3 SUBS, 4 RSBS, 5 MULS, 6 ANDS, 7 ORRS, 8 CMP)
- in_a, in_b  in  DATA_W  ALU operands (V computation)
- in_result  in  DATA_W  ALU result
- in_carry  in  1  ALU carry (meaningful for opcodes 0, 2)
- in_negative, in_zero  in  1  ALU N/Z (used for CMP only)
- in_dest  in  TAG_W  destination tag
- out_valid  out  1  FIFO head valid
- out_ready  in  1  register file accepts
- out_result  out  DATA_W  head result
- out_dest  out  TAG_W  head tag
- flags  out  4  architectural {N,Z,C,V}
- err_illegal  out  1  one-cycle pulse: opcode 9–15 accepted

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = (count < 2). A full FIFO never accepts, even if popped in the same cycle.
- Pop occurs when out_valid && out_ready.
- Flag computation on accept:
  - N = in_result[DATA_W-1]
  - Z = (in_result == 0)
  - CMP uses in_negative/in_zero instead.
- Flag update policy per opcode:
  - 0, 2: update N, Z, C, V.
  - 1, 3, 4, 5, 6, 7: update N, Z only; C and V hold.
  - 8: update N, Z only; no FIFO push.
  - 9–15: no flag change, no push, err_illegal = 1 next cycle.
- V (macro enabled):
  - opcode 0: (a[msb] == b[msb]) && (result[msb] != a[msb])
  - opcode 2: (a[msb] != b[msb]) && (result[msb] != a[msb])
- Opcodes 0–7 push {in_result, in_dest}.
- FIFO: 2 entries, pointer-based, wraps mod 2, strictly in order.
- Simultaneous push and pop at count 1: count stays 1, head advances, new entry becomes head.
- Push and pop at count 0 cannot coincide (out_valid = 0).
- A CMP accept plus a pop in the same cycle: pop only affects count; flags update.

## Timing
- Reset values: out_valid 0, count 0, pointers 0, flags 4'b0000, err_illegal 0, out_result/out_dest 0.
- Reset mid-operation: FIFO contents discarded, flags cleared, in_ready = 1 the cycle after reset deasserts.
- Latency: accept at edge t gives out_valid = 1 and data visible after edge t. A pop is possible at edge t+1.
- flags reflect an accepted instruction after the same edge that accepts it.
- Throughput: 1/cycle sustained while out_ready = 1.
- in_ready and out_valid are pure functions of registered count; no combinational in→out path.
- out_result/out_dest stable while out_valid && !out_ready.

## Configuration
- ALU_WB_OVF_EN:
  - Defined: V computed as above for opcodes 0 and 2.
  - Undefined: V bit of flags is constant 0; in_a/in_b are unused and no overflow logic is synthesized.

## Structure
- Shared package alu_pkg:
  - opcode enum (ADCS..CMP, 4 bits)
  - flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - function returning the per-opcode update mask {updN, updZ, updC, updV, push, illegal}
- One sub-module: wb_fifo2 (parameterised 2-entry valid/ready FIFO, width DATA_W+TAG_W).
- Flag logic stays in the top level.

## Test plan
- Reset, then ADD result 0x0000_0000, dest 3 → out_valid next cycle, out_result 0, out_dest 3; flags = 0100 (Z set, C/V held 0).
- ADCS a=0x7FFF_FFFF, b=1, result 0x8000_0000, carry 0 → flags 1001 with ALU_WB_OVF_EN, 1000 without.
- SBCS carry=1, then ANDS result 0x10 → flags after ANDS: N=0, Z=0, C=1 (held).
- out_ready=0, push three results → third stalls with in_ready=0. Raise out_ready → outputs drain in order 1, 2, 3, one per cycle.
- CMP in_zero=1 while FIFO full → CMP stalls until a pop. On accept Z=1 and count is unchanged.
- Opcode 12 accepted → err_illegal pulses 1 cycle, flags and FIFO unchanged. Assert rst_n=0 mid-stream with 2 entries → out_valid 0 and flags 0000 next cycle.
